// File: rtl/score_display_pkg.sv
// Shared constants, types and helpers for the score overlay.
package score_display_pkg;

  localparam int SCORE_GLYPH_W    = 8;
  localparam int SCORE_GLYPH_H    = 16;
  localparam int SCORE_MAX_DIGITS = 3;
  localparam int COLOR_BIT_WIDTH  = 12;
  localparam int SCORE_WIDTH_DEC  = 4 * SCORE_MAX_DIGITS;
  localparam int SCORE_LAT        = 2;

  typedef enum logic {
    FL_IDLE  = 1'b0,
    FL_FLASH = 1'b1
  } flash_state_t;

  // Slot-decode result carried through the first pipeline stage.
  typedef struct packed {
    logic       hit;
    logic [2:0] col;
  } s1_t;

  // Nibble idx of a BCD word; idx 0 is the ones digit.
  function automatic logic [3:0] bcd_nibble(input logic [SCORE_WIDTH_DEC-1:0] v,
                                            input logic [1:0] idx);
    case (idx)
      2'd0:    return v[3:0];
      2'd1:    return v[7:4];
      2'd2:    return v[11:8];
      default: return 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/score_display_if.sv
// Score/pixel bus between the video timing side and the score overlay.
interface score_display_if #(
  parameter int COLOR_W = score_display_pkg::COLOR_BIT_WIDTH
) ();
  import score_display_pkg::*;

  logic [SCORE_WIDTH_DEC-1:0] score_i;
  logic [1:0]                 score_digit_i;
  logic                       frame_start_i;
  logic                       pix_valid_i;
  logic [9:0]                 pix_x_i;
  logic [9:0]                 pix_y_i;
  logic                       pix_valid_o;
  logic                       pix_on_o;
  logic [COLOR_W-1:0]         pix_color_o;

  modport master (
    output score_i, score_digit_i, frame_start_i, pix_valid_i, pix_x_i, pix_y_i,
    input  pix_valid_o, pix_on_o, pix_color_o
  );

  modport slave (
    input  score_i, score_digit_i, frame_start_i, pix_valid_i, pix_x_i, pix_y_i,
    output pix_valid_o, pix_on_o, pix_color_o
  );

endinterface

// File: rtl/score_display_glyph_rom.sv
// 10 x 16 x 8 digit font, seven-segment style, one-cycle synchronous read.
// Address is {digit, row}; digits above 9 read as blank rows.
module digit_glyph_rom
  import score_display_pkg::*;
(
  input  logic       clk_vga,
  input  logic       rst,
  input  logic [7:0] addr_i,
  output logic [7:0] data_o
);

  // Segment mask {a,b,c,d,e,f,g} per digit; 0 for illegal BCD.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h7E;
      4'd1:    return 7'h30;
      4'd2:    return 7'h6D;
      4'd3:    return 7'h79;
      4'd4:    return 7'h33;
      4'd5:    return 7'h5B;
      4'd6:    return 7'h5F;
      4'd7:    return 7'h70;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h7B;
      default: return 7'h00;
    endcase
  endfunction

  logic [6:0] seg;
  logic [3:0] row;
  logic [7:0] row_d, data_q;

  // Expand segments into row bands: rows 0 and 15 are blank padding.
  always_comb begin
    seg   = seg_of(addr_i[7:4]);
    row   = addr_i[3:0];
    row_d = 8'h00;
    if (row == 4'd0 || row == 4'd15) row_d = 8'h00;
    else if (row <= 4'd2)  row_d = seg[6] ? 8'h7E : 8'h00;
    else if (row <= 4'd6)  row_d = (seg[1] ? 8'h60 : 8'h00) | (seg[5] ? 8'h06 : 8'h00);
    else if (row <= 4'd8)  row_d = seg[0] ? 8'h7E : 8'h00;
    else if (row <= 4'd12) row_d = (seg[2] ? 8'h60 : 8'h00) | (seg[4] ? 8'h06 : 8'h00);
    else                   row_d = seg[3] ? 8'h7E : 8'h00;
  end

  // Registered read port.
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) data_q <= 8'h00;
    else     data_q <= row_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/score_display.sv
// Score overlay: per-frame score snapshot, slot decode, glyph lookup,
// flash-after-change colouring. Two-cycle pixel pipeline.
module score_display
  import score_display_pkg::*;
#(
  parameter int unsigned        ORIGIN_X     = 16,
  parameter int unsigned        ORIGIN_Y     = 16,
  parameter int unsigned        DIGIT_GAP    = 2,
  parameter int unsigned        COLOR_W      = COLOR_BIT_WIDTH,
  parameter logic [COLOR_W-1:0] COLOR_FG     = 12'hFFF,
  parameter logic [COLOR_W-1:0] COLOR_FLASH  = 12'hFF0,
  parameter int unsigned        FLASH_FRAMES = 30,
  parameter int unsigned        FLASH_PERIOD = 4
) (
  input  logic             clk_vga,
  input  logic             rst,
  score_display_if.slave   vif
);

  localparam int unsigned SLOT_PITCH = SCORE_GLYPH_W + DIGIT_GAP;
  localparam int unsigned FC_W       = $clog2(FLASH_FRAMES);
  localparam logic [10:0] OX         = 11'(ORIGIN_X);
  localparam logic [10:0] OY         = 11'(ORIGIN_Y);

  // Snapshot registers
  logic [SCORE_WIDTH_DEC-1:0] snap_q, snap_d, prev_q, prev_d;
  logic [1:0]                 nd_q, nd_d;
  logic                       evt_q;
  logic                       changed;

  // Flash FSM
  flash_state_t    state_q, state_d;
  logic [FC_W-1:0] fc_q, fc_d;
  logic [31:0]     phase;
  logic            flash_col;

  // Pixel pipeline
  logic [10:0]          x11, y11, base;
  logic                 in_row, hit_d;
  logic [3:0]           nib_d, row_d;
  logic [2:0]           col_d;
  logic [1:0]           sel;
  logic [7:0]           rom_row;
  s1_t                  s1_q;
  logic [SCORE_LAT:1]   vld_pipe_q;
  logic                 on_d, pix_on_q;
  logic [COLOR_W-1:0]   color_d, pix_color_q;

  assign x11 = {1'b0, vif.pix_x_i};
  assign y11 = {1'b0, vif.pix_y_i};

  // Capture score only at frame start so a frame never tears.
  always_comb begin
    snap_d = snap_q;
    prev_d = prev_q;
    nd_d   = nd_q;
    if (vif.frame_start_i) begin
      prev_d = snap_q;
      snap_d = vif.score_i;
      nd_d   = (vif.score_digit_i == 2'd0) ? 2'd1 : vif.score_digit_i;
    end
  end

  // Snapshot state; evt_q marks the cycle the fresh snapshot is visible.
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      snap_q <= '0;
      prev_q <= '0;
      nd_q   <= 2'd1;
      evt_q  <= 1'b0;
    end else begin
      snap_q <= snap_d;
      prev_q <= prev_d;
      nd_q   <= nd_d;
      evt_q  <= vif.frame_start_i;
    end
  end

  assign changed = evt_q && (snap_q != prev_q);

  // Flash next-state: a change always restarts, even on the expiry frame.
  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    case (state_q)
      FL_IDLE: begin
        if (changed) begin
          state_d = FL_FLASH;
          fc_d    = '0;
        end
      end
      FL_FLASH: begin
        if (changed) begin
          fc_d = '0;
        end else if (evt_q) begin
          if (fc_q == FC_W'(FLASH_FRAMES - 1)) begin
            state_d = FL_IDLE;
            fc_d    = '0;
          end else begin
            fc_d = fc_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = FL_IDLE;
        fc_d    = '0;
      end
    endcase
  end

  // Flash state register.
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      state_q <= FL_IDLE;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
    end
  end

  // Alternate colour on even flash phases.
  always_comb begin
    phase     = 32'(fc_q) / FLASH_PERIOD;
    flash_col = (state_q == FL_FLASH) && !phase[0];
  end

  // Slot decode; 11-bit unsigned compares keep x<ORIGIN_X out of every slot.
  always_comb begin
    hit_d  = 1'b0;
    nib_d  = 4'h0;
    col_d  = 3'd0;
    base   = '0;
    sel    = 2'd0;
    row_d  = 4'(y11 - OY);
    in_row = (y11 >= OY) && (y11 < OY + 11'(SCORE_GLYPH_H));
    for (int k = 0; k < SCORE_MAX_DIGITS; k++) begin
      base = OX + 11'(k * SLOT_PITCH);
      if (in_row && (2'(k) < nd_q) && (x11 >= base) && (x11 < base + 11'(SCORE_GLYPH_W))) begin
        hit_d = 1'b1;
        col_d = 3'(x11 - base);
        sel   = nd_q - 2'(k) - 2'd1;
        nib_d = bcd_nibble(snap_q, sel);
      end
    end
  end

  // The ROM read register holds the S1 nibble/row lookup.
  digit_glyph_rom u_rom (
    .clk_vga (clk_vga),
    .rst     (rst),
    .addr_i  ({nib_d, row_d}),
    .data_o  (rom_row)
  );

  // S2 combinational: pick the column bit (bit 7 is leftmost) and colour.
  always_comb begin
    on_d    = s1_q.hit & vld_pipe_q[1] & rom_row[~s1_q.col];
    color_d = on_d ? (flash_col ? COLOR_FLASH : COLOR_FG) : '0;
  end

  // S1 and S2 registers plus valid shift register.
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      s1_q        <= '0;
      vld_pipe_q  <= '0;
      pix_on_q    <= 1'b0;
      pix_color_q <= '0;
    end else begin
      s1_q.hit    <= hit_d;
      s1_q.col    <= col_d;
      vld_pipe_q  <= {vld_pipe_q[SCORE_LAT-1:1], vif.pix_valid_i};
      pix_on_q    <= on_d;
      pix_color_q <= color_d;
    end
  end

  assign vif.pix_valid_o = vld_pipe_q[SCORE_LAT];
  assign vif.pix_on_o    = pix_on_q;
  assign vif.pix_color_o = pix_color_q;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: vector table, region scans against a
// pixel model, flash-colour sequences, reset-in-line.
module tb_score_display;
  import score_display_pkg::*;

  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] FL = 12'hFF0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  score_display_if vif ();

  score_display dut (
    .clk_vga (clk),
    .rst     (rst),
    .vif     (vif.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          x;
    int          y;
    logic        v;
    logic        on;
    logic [11:0] col;
  } vec_t;

  vec_t tv[17];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Hand-drawn font: bands {top, upper, middle, lower, bottom}.
  function automatic logic [7:0] g_row(input logic [3:0] d, input int r);
    logic [39:0] t;
    int bi;
    case (d)
      4'd0: t = 40'h7E_66_00_66_7E;
      4'd1: t = 40'h00_06_00_06_00;
      4'd2: t = 40'h7E_06_7E_60_7E;
      4'd3: t = 40'h7E_06_7E_06_7E;
      4'd4: t = 40'h00_66_7E_06_00;
      4'd5: t = 40'h7E_60_7E_06_7E;
      4'd6: t = 40'h7E_60_7E_66_7E;
      4'd7: t = 40'h7E_06_00_06_00;
      4'd8: t = 40'h7E_66_7E_66_7E;
      default: t = 40'h7E_66_7E_06_7E;
    endcase
    if (r == 0 || r == 15) return 8'h00;
    bi = (r < 3) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : (r < 13) ? 3 : 4;
    return t[39 - 8*bi -: 8];
  endfunction

  function automatic logic exp_on(input int x, input int y, input logic [11:0] snap, input int nd);
    logic r;
    r = 1'b0;
    for (int k = 0; k < nd; k++) begin
      int base;
      base = 16 + 10*k;
      if (x >= base && x < base + 8 && y >= 16 && y < 32) begin
        logic [3:0] nib;
        logic [7:0] rw;
        nib = snap[4*(nd-1-k) +: 4];
        if (nib <= 4'd9) begin
          rw = g_row(nib, y - 16);
          r  = rw[7 - (x - base)];
        end
      end
    end
    return r;
  endfunction

  task automatic drive(input int x, input int y, input logic v);
    vif.pix_x_i     = 10'(x);
    vif.pix_y_i     = 10'(y);
    vif.pix_valid_i = v;
  endtask

  task automatic frame(input logic [11:0] s, input logic [1:0] d);
    @(negedge clk);
    vif.score_i       = s;
    vif.score_digit_i = d;
    vif.frame_start_i = 1'b1;
    @(negedge clk);
    vif.frame_start_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Stream a region one pixel per cycle; each output is checked two cycles
  // after its pixel was driven.
  task automatic scan(input string name, input logic [11:0] snap, input int nd, input logic [11:0] col);
    logic [13:0] p1, p2;
    logic h1, h2, e;
    h1 = 1'b0; h2 = 1'b0; p1 = '0; p2 = '0;
    for (int y = 14; y < 34; y++) begin
      for (int x = 12; x < 48; x++) begin
        @(negedge clk);
        if (h2) check(name, {vif.pix_valid_o, vif.pix_on_o, vif.pix_color_o}, 32'(p2));
        p2 = p1; h2 = h1;
        drive(x, y, 1'b1);
        e  = exp_on(x, y, snap, nd);
        p1 = {1'b1, e, e ? col : 12'h000};
        h1 = 1'b1;
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (h2) check(name, {vif.pix_valid_o, vif.pix_on_o, vif.pix_color_o}, 32'(p2));
      p2 = p1; h2 = h1;
      drive(0, 0, 1'b0);
      p1 = '0;
    end
  endtask

  task automatic probe(input int x, input int y, output logic on, output logic [11:0] col);
    @(negedge clk);
    drive(x, y, 1'b1);
    repeat (2) @(negedge clk);
    on  = vif.pix_on_o;
    col = vif.pix_color_o;
  endtask

  initial begin
    logic        on;
    logic [11:0] col;
    logic [11:0] ec;
    int          fc;

    tv[0]  = '{17, 17, 1'b1, 1'b1, FL};
    tv[1]  = '{16, 17, 1'b1, 1'b0, 12'h000};
    tv[2]  = '{24, 20, 1'b1, 1'b0, 12'h000};
    tv[3]  = '{25, 20, 1'b1, 1'b0, 12'h000};
    tv[4]  = '{26, 16, 1'b1, 1'b0, 12'h000};
    tv[5]  = '{27, 17, 1'b1, 1'b1, FL};
    tv[6]  = '{26, 19, 1'b1, 1'b0, 12'h000};
    tv[7]  = '{27, 19, 1'b1, 1'b1, FL};
    tv[8]  = '{37, 17, 1'b1, 1'b1, FL};
    tv[9]  = '{37, 23, 1'b1, 1'b0, 12'h000};
    tv[10] = '{18, 23, 1'b1, 1'b1, FL};
    tv[11] = '{15, 17, 1'b1, 1'b0, 12'h000};
    tv[12] = '{46, 17, 1'b1, 1'b0, 12'h000};
    tv[13] = '{17, 32, 1'b1, 1'b0, 12'h000};
    tv[14] = '{17, 15, 1'b1, 1'b0, 12'h000};
    tv[15] = '{17, 17, 1'b0, 1'b0, 12'h000};
    tv[16] = '{32, 30, 1'b1, 1'b1, FL};

    vif.score_i       = '0;
    vif.score_digit_i = 2'd0;
    vif.frame_start_i = 1'b0;
    drive(17, 17, 1'b1);

    // Reset holds every output low even with a lit pixel on the inputs.
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(vif.pix_valid_o), 32'd0);
    check("rst_on",    32'(vif.pix_on_o),    32'd0);
    check("rst_color", 32'(vif.pix_color_o), 32'd0);
    rst = 1'b0;

    // Score 0 with digit count 0: a single "0" in the normal colour.
    frame(12'h000, 2'd0);
    scan("zero", 12'h000, 1, FG);

    // 307: first frame after a change, so flash colour.
    frame(12'h307, 2'd3);
    scan("s307", 12'h307, 3, FL);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(tv[i].x, tv[i].y, tv[i].v);
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d", i), {vif.pix_valid_o, vif.pix_on_o, vif.pix_color_o},
            32'({tv[i].v, tv[i].on, tv[i].col}));
    end

    // Exactly two cycles from pixel to overlay.
    @(negedge clk); drive(0, 0, 1'b1);
    @(negedge clk); drive(17, 17, 1'b1);
    @(negedge clk); drive(0, 0, 1'b1);
    check("lat_early", 32'(vif.pix_on_o), 32'd0);
    @(negedge clk);
    check("lat_two", 32'(vif.pix_on_o), 32'd1);
    @(negedge clk);
    check("lat_after", 32'(vif.pix_on_o), 32'd0);

    // Score moves mid-frame: picture unchanged until the next frame start.
    vif.score_i       = 12'h999;
    vif.score_digit_i = 2'd1;
    scan("hold", 12'h307, 3, FL);

    // Illegal middle nibble renders blank.
    frame(12'h3A7, 2'd3);
    scan("badnib", 12'h3A7, 3, FL);

    // Run 041 to fc=29, then change on the expiry frame: change must win.
    frame(12'h041, 2'd2);
    for (int i = 1; i < 30; i++) frame(12'h041, 2'd2);
    for (int f = 0; f < 34; f++) begin
      frame(12'h042, 2'd2);
      probe(17, 19, on, col);
      ec = (f < 30 && ((f / 4) % 2 == 0)) ? FL : FG;
      check($sformatf("flash_f%0d", f), 32'({on, col}), 32'({1'b1, ec}));
    end

    // Change again at frame 10 restarts the count.
    for (int g = 0; g < 21; g++) begin
      frame((g < 10) ? 12'h043 : 12'h044, 2'd2);
      probe(17, 19, on, col);
      fc = (g < 10) ? g : g - 10;
      ec = ((fc / 4) % 2 == 0) ? FL : FG;
      check($sformatf("restart_g%0d", g), 32'({on, col}), 32'({1'b1, ec}));
    end

    // Reset mid-line clears outputs within the cycle.
    @(negedge clk); drive(17, 19, 1'b1);
    repeat (2) @(negedge clk);
    check("pre_rst_on", 32'(vif.pix_on_o), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_on",    32'(vif.pix_on_o),    32'd0);
    check("mid_rst_color", 32'(vif.pix_color_o), 32'd0);
    check("mid_rst_valid", 32'(vif.pix_valid_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
